pc_unit: RTL and testbench
==========================

// Module: pc_unit
// PURPOSE
//  - Parametrised program-counter unit for the core fetch stage.
//  - Holds the fetch PC and selects the next PC each cycle from: sequential
//    increment, PC-relative branch, absolute jump/call, or subroutine return.
//  - Supports stall and an optional hardware return-address stack (RAS).
//  - Drives instruction-memory address; fed by decode/branch-resolve logic.
// PARAMETERS
//  PC_W       6    PC width in bits; all PC arithmetic is modulo 2^PC_W
//  INC        1    sequential increment per instruction
//  OFF_W      6    branch offset width, two's complement, sign-extended to PC_W
//  RESET_VEC  0    PC value loaded on reset
//  RAS_DEPTH  4    return-stack entries (RAS_EN builds only), power of 2, >=2
// PORTS
//  clk           in   1      clock, rising edge
//  rst           in   1      reset, synchronous, active-high
//  stall         in   1      hold PC; no RAS push/pop
//  branch_taken  in   1      take PC-relative branch this cycle
//  branch_off    in   OFF_W  signed offset added to pc_out
//  jump_valid    in   1      load jump_target
//  jump_target   in   PC_W   absolute target
//  call          in   1      with jump_valid: push return address (RAS_EN)
//  ret           in   1      pop RAS, go to popped address (RAS_EN)
//  pc_out        out  PC_W   current fetch PC (registered)
//  pc_next       out  PC_W   combinational next-PC value
//  ras_ovf       out  1      sticky: push occurred while RAS full
//  ras_unf       out  1      1-cycle pulse: ret while RAS empty
// BEHAVIOUR
//  - reset, synchronous, active-high; clock clk. On rst: pc_out=RESET_VEC,
//    RAS emptied, ras_ovf=0, ras_unf=0. rst overrides every other input.
//  - pc_out updates on posedge clk to pc_next; latency 1 cycle.
//  - pc_next priority: stall -> pc_out; jump_valid -> jump_target;
//    branch_taken -> pc_out+sext(branch_off); ret -> RAS top;
//    else pc_out+INC. All sums truncated to PC_W (wrap, no flag).
//  - Lower-priority requests in the same cycle are dropped, not queued.
//  - call without jump_valid: ignored. call & ret with jump_valid: call wins,
//    ret ignored (no pop).
//  - Stall asserted: pc_out, RAS and ras_ovf unchanged; ras_unf=0.
//  - RAS: push value = pc_out+INC (mod 2^PC_W). Full push overwrites oldest
//    entry (circular), depth stays RAS_DEPTH, ras_ovf set until rst.
//  - ret on empty RAS: pc_next=pc_out+INC, ras_unf=1 for that cycle, no pop.
//  - ret when ret is overridden by jump/branch: no pop.
// CONFIGURATION
//  - Macro PC_UNIT_RAS_EN.
//  - Defined: RAS instantiated; call/ret behave as above.
//  - Undefined: no RAS storage; call acts as a plain jump qualifier (ignored);
//    ret ignored (falls to sequential); ras_ovf, ras_unf tied 0.
// STRUCTURE
//  - pc_pkg: PC_W/INC defaults, pc_sel_t enum {SEL_HOLD, SEL_JUMP, SEL_BRANCH,
//    SEL_RET, SEL_SEQ}, sext helper function.
//  - Sub-module pc_ras: circular stack (push, pop, top, empty, full),
//    parameters PC_W, RAS_DEPTH; instantiated only under PC_UNIT_RAS_EN.
//  - Top: next-PC mux from pc_sel_t, PC register, flag logic.
// TESTING (PC_W=6, INC=1, OFF_W=6, RESET_VEC=0, RAS_DEPTH=4, RAS_EN on)
//  - rst 1 cycle then idle 3 cycles -> pc_out 0,1,2,3; hold at 63 -> wraps
//    to 0.
//  - pc_out=10, branch_taken, branch_off=-4 (6'h3C) -> pc_out=6 next cycle;
//    same cycle with jump_valid, jump_target=40 -> pc_out=40.
//  - pc_out=5, stall 3 cycles with branch_taken -> pc_out stays 5; release
//    -> 6.
//  - pc_out=8, call+jump_valid to 30; then ret -> pc_out 30 then 9; 5 nested
//    calls -> ras_ovf=1, 5 rets return 4 addresses then ras_unf pulse.
//  - ret on empty RAS at pc_out=12 -> pc_out=13, ras_unf=1 one cycle.
//  - rst asserted mid-call sequence -> pc_out=0, RAS empty, flags 0;
//    RAS_EN off: call/ret no effect on sequence.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage program-counter unit.
`default_nettype none

package pc_pkg;

    localparam int PC_W_DEF = 6;
    localparam int INC_DEF  = 1;

    typedef enum logic [2:0] {
        SEL_HOLD   = 3'd0,
        SEL_JUMP   = 3'd1,
        SEL_BRANCH = 3'd2,
        SEL_RET    = 3'd3,
        SEL_SEQ    = 3'd4
    } pc_sel_t;

    // Sign-extends the low w bits of v to 32 bits; callers truncate to PC width.
    function automatic logic [31:0] sext(input logic [31:0] v, input int w);
        logic [31:0] hi_mask;
        hi_mask = 32'hFFFF_FFFF << w;
        return v[w-1] ? (v | hi_mask) : (v & ~hi_mask);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_ras.sv
// Circular hardware return-address stack; a push when full overwrites the
// oldest entry so the most recent RAS_DEPTH return addresses are kept.
`default_nettype none

module pc_ras #(
    parameter int PC_W      = 6,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top,
    output logic            empty,
    output logic            full
);

    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic [PC_W-1:0]  mem [RAS_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;

    assign empty = (count == '0);
    assign full  = (count == (PTR_W+1)'(RAS_DEPTH));
    assign top   = mem[wr_ptr - PTR_W'(1)];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (!full)
                count <= count + (PTR_W+1)'(1);
        end else if (pop && !empty) begin
            wr_ptr <= wr_ptr - PTR_W'(1);
            count  <= count - (PTR_W+1)'(1);
        end
    end

    // Storage needs no reset: occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (!rst && push)
            mem[wr_ptr] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/pc_unit.sv
// Fetch-stage program counter: next-PC select, PC register and RAS flags.
// Optional return-address stack enabled by defining PC_UNIT_RAS_EN.
`default_nettype none

module pc_unit
    import pc_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int INC       = INC_DEF,
    parameter int OFF_W     = 6,
    parameter int RESET_VEC = 0,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [OFF_W-1:0] branch_off,
    input  logic             jump_valid,
    input  logic [PC_W-1:0]  jump_target,
    input  logic             call,
    input  logic             ret,
    output logic [PC_W-1:0]  pc_out,
    output logic [PC_W-1:0]  pc_next,
    output logic             ras_ovf,
    output logic             ras_unf
);

    pc_sel_t         sel;
    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] branch_pc;
    logic [PC_W-1:0] ras_top;
    logic            ras_empty;
    logic            ras_full;
    logic            ras_push;
    logic            ras_pop;

    assign seq_pc    = pc_out + PC_W'(INC);
    assign branch_pc = pc_out + PC_W'(sext(32'(branch_off), OFF_W));

`ifdef PC_UNIT_RAS_EN
    pc_ras #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (seq_pc),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    assign ras_push = !stall && jump_valid && call;
    assign ras_pop  = (sel == SEL_RET);
    // Underflow only when ret actually won arbitration against an empty stack.
    assign ras_unf  = !rst && !stall && !jump_valid && !branch_taken && ret && ras_empty;

    always_ff @(posedge clk) begin
        if (rst)
            ras_ovf <= 1'b0;
        else if (ras_push && ras_full)
            ras_ovf <= 1'b1;
    end
`else
    logic unused_ras_ok;
    assign unused_ras_ok = &{1'b0, call, ret, ras_push, ras_pop, ras_full};
    assign ras_top   = '0;
    assign ras_empty = 1'b1;
    assign ras_full  = 1'b0;
    assign ras_push  = 1'b0;
    assign ras_pop   = 1'b0;
    assign ras_unf   = 1'b0;
    assign ras_ovf   = 1'b0;
`endif

    always_comb begin
        sel = SEL_SEQ;
        if (stall)
            sel = SEL_HOLD;
        else if (jump_valid)
            sel = SEL_JUMP;
        else if (branch_taken)
            sel = SEL_BRANCH;
        else if (ret && !ras_empty)
            sel = SEL_RET;
    end

    always_comb begin
        pc_next = seq_pc;
        case (sel)
            SEL_HOLD:   pc_next = pc_out;
            SEL_JUMP:   pc_next = jump_target;
            SEL_BRANCH: pc_next = branch_pc;
            SEL_RET:    pc_next = ras_top;
            default:    pc_next = seq_pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            pc_out <= PC_W'(RESET_VEC);
        else
            pc_out <= pc_next;
    end

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
// Directed plus pseudo-random bench for pc_unit with a queue-based scoreboard.
`default_nettype none

module tb_pc_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       stall = 1'b0;
    logic       branch_taken = 1'b0;
    logic [5:0] branch_off = '0;
    logic       jump_valid = 1'b0;
    logic [5:0] jump_target = '0;
    logic       call = 1'b0;
    logic       ret = 1'b0;
    logic [5:0] pc_out;
    logic [5:0] pc_next;
    logic       ras_ovf;
    logic       ras_unf;

    typedef struct packed {
        logic [5:0] pc;
        logic       unf;
        logic       ovf;
    } exp_t;

    exp_t       exp_q[$];
    logic [5:0] m_stack[$];
    logic [5:0] m_pc = '0;
    logic       m_ovf = 1'b0;
    int         tests = 0;
    int         fails = 0;

`ifdef PC_UNIT_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    pc_unit #(
        .PC_W(6), .INC(1), .OFF_W(6), .RESET_VEC(0), .RAS_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_off(branch_off), .jump_valid(jump_valid), .jump_target(jump_target),
        .call(call), .ret(ret), .pc_out(pc_out), .pc_next(pc_next),
        .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle, predict it with the model, check comb then registered outputs.
    task automatic step(input string tag, input logic s, input logic b, input logic [5:0] off,
                        input logic j, input logic [5:0] jt, input logic c, input logic r);
        exp_t e;
        stall = s; branch_taken = b; branch_off = off;
        jump_valid = j; jump_target = jt; call = c; ret = r;
        e.unf = 1'b0;
        if (s) begin
            e.pc = m_pc;
        end else if (j) begin
            e.pc = jt;
            if (c && RAS_ON) begin
                if (m_stack.size() == 4) begin
                    void'(m_stack.pop_front());
                    m_ovf = 1'b1;
                end
                m_stack.push_back(m_pc + 6'd1);
            end
        end else if (b) begin
            e.pc = m_pc + off;
        end else if (r && RAS_ON && m_stack.size() > 0) begin
            e.pc = m_stack.pop_back();
        end else begin
            e.pc = m_pc + 6'd1;
            e.unf = r && RAS_ON;
        end
        e.ovf = m_ovf;
        m_pc = e.pc;
        exp_q.push_back(e);
        @(negedge clk);
        chk({tag, ".pc_next"}, 8'(pc_next), 8'(exp_q[0].pc));
        chk({tag, ".ras_unf"}, 8'(ras_unf), 8'(exp_q[0].unf));
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, ".pc_out"}, 8'(pc_out), 8'(e.pc));
        chk({tag, ".ras_ovf"}, 8'(ras_ovf), 8'(e.ovf));
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 6'd0, 0, 6'd0, 0, 0);
    endtask

    task automatic jump(input string tag, input logic [5:0] t);
        step(tag, 0, 0, 6'd0, 1, t, 0, 0);
    endtask

    task automatic do_reset(input string tag, input logic c, input logic j, input logic r);
        rst = 1'b1; call = c; jump_valid = j; ret = r; stall = 1'b0; branch_taken = 1'b0;
        jump_target = 6'd33;
        @(posedge clk);
        #1;
        chk({tag, ".ras_unf_in_rst"}, 8'(ras_unf), 8'd0);
        rst = 1'b0; call = 1'b0; jump_valid = 1'b0; ret = 1'b0;
        m_pc = '0; m_ovf = 1'b0; m_stack.delete();
        chk({tag, ".pc_out"}, 8'(pc_out), 8'd0);
        chk({tag, ".ras_ovf"}, 8'(ras_ovf), 8'd0);
        chk({tag, ".ras_unf"}, 8'(ras_unf), 8'd0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset("rst0", 0, 0, 0);
        idle("seq1"); idle("seq2"); idle("seq3");
        jump("to63", 6'd63);
        idle("wrap0");

        jump("to10a", 6'd10);
        step("br_neg4", 0, 1, 6'h3C, 0, 6'd0, 0, 0);
        jump("to10b", 6'd10);
        step("br_vs_jump", 0, 1, 6'h3C, 1, 6'd40, 0, 0);
        step("br_pos_wrap", 0, 1, 6'd31, 0, 6'd0, 0, 0);

        jump("to5", 6'd5);
        step("stall1", 1, 1, 6'd7, 0, 6'd0, 0, 0);
        step("stall2", 1, 1, 6'd7, 1, 6'd20, 1, 0);
        step("stall3", 1, 1, 6'd7, 0, 6'd0, 0, 1);
        idle("unstall");

        jump("to8", 6'd8);
        step("call30", 0, 0, 6'd0, 1, 6'd30, 1, 0);
        step("ret9", 0, 0, 6'd0, 0, 6'd0, 0, 1);

        for (int i = 0; i < 5; i++)
            step($sformatf("ncall%0d", i), 0, 0, 6'd0, 1, 6'(10 * i + 3), 1, 0);
        for (int i = 0; i < 5; i++)
            step($sformatf("nret%0d", i), 0, 0, 6'd0, 0, 6'd0, 0, 1);

        jump("to12", 6'd12);
        step("ret_empty", 0, 0, 6'd0, 0, 6'd0, 0, 1);
        idle("unf_clear");

        step("call_ret_jv", 0, 0, 6'd0, 1, 6'd50, 1, 1);
        step("ret_vs_br", 0, 1, 6'd2, 0, 6'd0, 0, 1);
        step("call_no_jv", 0, 0, 6'd0, 0, 6'd0, 1, 0);
        step("ret_pop", 0, 0, 6'd0, 0, 6'd0, 0, 1);

        step("pre_rst_call", 0, 0, 6'd0, 1, 6'd44, 1, 0);
        do_reset("rst_mid", 1, 1, 1);
        step("ret_after_rst", 0, 0, 6'd0, 0, 6'd0, 0, 1);

        for (int i = 0; i < 60; i++)
            step($sformatf("rnd%0d", i), ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
                 6'($urandom), ($urandom_range(0, 3) == 0), 6'($urandom),
                 ($urandom_range(0, 1) == 0), ($urandom_range(0, 2) == 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
